// File: rtl/flag_register_unit.sv
// flag_register_unit: condition flag registers with a LIFO shadow stack for interrupt save/restore
module flag_register_unit #(
  parameter int FLAG_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Stall,
  input  logic [FLAG_W-1:0]        ALUFlags1,
  input  logic [FLAG_W-1:0]        ALUFlags2,
  input  logic [1:0]               FlagW,
  input  logic                     CondEx,
  input  logic                     Push,
  input  logic                     Pop,
  input  logic                     ClrErr,
  output logic [FLAG_W-1:0]        Flags1,
  output logic [FLAG_W-1:0]        Flags2,
  output logic [FLAG_W-1:0]        Flags1Next,
  output logic [FLAG_W-1:0]        Flags2Next,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Overflow,
  output logic                     Underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [2*FLAG_W-1:0] stack [DEPTH];
  logic [2*FLAG_W-1:0] top;
  logic do_push, do_pop, push_ok, pop_ok, w1, w2;
  assign Full  = Level == LW'(DEPTH);
  assign Empty = Level == '0;
  assign top   = stack[AW'(Level - 1'b1)];
  // a successful pop overrides any same-cycle flag write
  always_comb begin
    do_push    = ~Stall & Push & ~Pop;
    do_pop     = ~Stall & Pop & ~Push;
    push_ok    = do_push & ~Full;
    pop_ok     = do_pop & ~Empty;
    w1         = ~Stall & FlagW[0] & CondEx;
    w2         = ~Stall & FlagW[1] & CondEx;
    Flags1Next = pop_ok ? top[FLAG_W-1:0] : w1 ? ALUFlags1 : Flags1;
    Flags2Next = pop_ok ? top[2*FLAG_W-1:FLAG_W] : w2 ? ALUFlags2 : Flags2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      Flags1    <= '0;
      Flags2    <= '0;
      Level     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (!Stall) begin
      Flags1    <= Flags1Next;
      Flags2    <= Flags2Next;
      Level     <= push_ok ? Level + 1'b1 : pop_ok ? Level - 1'b1 : Level;
      Overflow  <= (do_push & Full) | (Overflow & ~ClrErr);
      Underflow <= (do_pop & Empty) | (Underflow & ~ClrErr);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) stack[Level[AW-1:0]] <= {Flags2, Flags1};
  end
endmodule
